// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: sequencer states and
// decoder SG bundle bit positions used by the decoder, datapath and sequencer.
package cpu_pkg;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    typedef enum logic [2:0] {
        ST_FETCH  = S_FETCH,
        ST_DECODE = S_DECODE,
        ST_EXEC   = S_EXEC,
        ST_MEM    = S_MEM,
        ST_WB     = S_WB,
        ST_HALT   = S_HALT
    } state_t;

    localparam int SG_W        = 12;
    localparam int SG_MEMTOR   = 0;
    localparam int SG_MEMWRITE = 1;
    localparam int SG_ALU_SRC  = 2;
    localparam int SG_REGWRITE = 3;
    localparam int SG_SYSCALL  = 4;
    localparam int SG_SIGNEDEX = 5;
    localparam int SG_REGDST   = 6;
    localparam int SG_BEQ      = 7;
    localparam int SG_BNE      = 8;
    localparam int SG_JR       = 9;
    localparam int SG_JMP      = 10;
    localparam int SG_JAL      = 11;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !(&cnt_q)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign q = cnt_q;

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: walks one instruction through FETCH..WB,
// issues PC/IR/regfile/dmem enables and keeps cycle and retire counters.
module multicycle_sequencer
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      sg,
    input  logic             br_eq,
    input  logic             halt_req,
    input  logic             go,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_we,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t state_q;
    state_t state_d;
    logic   taken;
    logic   mem_op;
    logic   retire;
    logic   cyc_en;

    // Bits consumed by the datapath only; folded here to document that.
    logic   unused_sg;
    assign unused_sg = ^{sg[SG_ALU_SRC], sg[SG_SIGNEDEX], sg[SG_REGDST],
                         sg[SG_JR], sg[SG_JAL]};

    assign taken  = sg[SG_JMP] | (sg[SG_BEQ] & br_eq) | (sg[SG_BNE] & ~br_eq);
    assign mem_op = sg[SG_MEMWRITE] | sg[SG_MEMTOR];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (imem_ack) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (sg[SG_SYSCALL] && halt_req)  state_d = ST_HALT;
                else if (mem_op)                 state_d = ST_MEM;
                else if (sg[SG_REGWRITE])        state_d = ST_WB;
                else                             state_d = ST_FETCH;
            end
            ST_MEM: begin
                if (dmem_ack) state_d = sg[SG_MEMTOR] ? ST_WB : ST_FETCH;
            end
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   if (go) state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes are state-decoded; only the fetch ack and EXEC branch terms are
    // combinational, and reset masks everything on the cycle it is asserted.
    assign imem_req = !rst && (state_q == ST_FETCH);
    assign ir_we    = imem_req && imem_ack;
    assign pc_sel   = !rst && (state_q == ST_EXEC) && taken;
    assign pc_we    = ir_we || pc_sel;
    assign dmem_req = !rst && (state_q == ST_MEM);
    assign dmem_we  = dmem_req && sg[SG_MEMWRITE];
    assign reg_we   = !rst && (state_q == ST_WB);
    assign halted   = !rst && (state_q == ST_HALT);

    assign retire = !rst
                 && ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB))
                 && ((state_d == ST_FETCH) || (state_d == ST_HALT));
    assign cyc_en = (state_q != ST_HALT);

    sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk (clk),
        .clr (rst),
        .en  (cyc_en),
        .q   (cyc_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_instr_cnt (
        .clk (clk),
        .clr (rst),
        .en  (retire),
        .q   (instr_cnt)
    );

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer built with 4-bit counters so that
// saturation is reachable in a short run.
module tb_multicycle_sequencer;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [11:0]   sg;
    logic          br_eq, halt_req, go, imem_ack, dmem_ack;
    logic          imem_req, ir_we, pc_we, pc_sel, dmem_req, dmem_we, reg_we, halted;
    logic [CW-1:0] cyc_cnt, instr_cnt;
    logic [6:0]    strb;

    int checks = 0;
    int errors = 0;

    localparam logic [11:0] SG_ADD = 12'h048;
    localparam logic [11:0] SG_LW  = 12'h00D;
    localparam logic [11:0] SG_SW  = 12'h006;
    localparam logic [11:0] SG_BEQ = 12'h080;
    localparam logic [11:0] SG_BNE = 12'h100;
    localparam logic [11:0] SG_J   = 12'h400;
    localparam logic [11:0] SG_SYS = 12'h010;

    // strobe vector order: imem_req ir_we pc_we pc_sel dmem_req dmem_we reg_we
    localparam logic [6:0] S_NONE  = 7'b0000000;
    localparam logic [6:0] S_FACK  = 7'b1110000;
    localparam logic [6:0] S_FREQ  = 7'b1000000;
    localparam logic [6:0] S_BR    = 7'b0011000;
    localparam logic [6:0] S_MRD   = 7'b0000100;
    localparam logic [6:0] S_MWR   = 7'b0000110;
    localparam logic [6:0] S_WB    = 7'b0000001;

    always #5 clk = ~clk;

    assign strb = {imem_req, ir_we, pc_we, pc_sel, dmem_req, dmem_we, reg_we};

    multicycle_sequencer #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .sg(sg), .br_eq(br_eq), .halt_req(halt_req),
        .go(go), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we),
        .halted(halted), .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_chk(input string tag, input logic [6:0] exp);
        #1;
        chk(tag, {25'd0, strb}, {25'd0, exp});
    endtask

    task automatic do_reset();
        rst = 1'b1; sg = '0; br_eq = 0; halt_req = 0; go = 0; imem_ack = 0; dmem_ack = 0;
        step(); step();
        rst = 1'b0;
        #1;
    endtask

    // Fetch with immediate ack, decode, then check the EXEC strobes.
    task automatic fde(input string tag, input logic [11:0] s, input logic b, input logic [6:0] exp_e);
        sg = s; br_eq = b; imem_ack = 1'b1;
        settle_chk({tag, "_F"}, S_FACK);
        step(); imem_ack = 1'b0;
        settle_chk({tag, "_D"}, S_NONE);
        step();
        settle_chk({tag, "_E"}, exp_e);
        step();
    endtask

    initial begin
        rst = 1'b1; sg = '0; br_eq = 0; halt_req = 0; go = 0; imem_ack = 1; dmem_ack = 1;
        step();
        settle_chk("rst_strobes", S_NONE);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        step();
        rst = 1'b0; imem_ack = 0; dmem_ack = 0;
        settle_chk("post_rst_fetch", S_FREQ);
        chk("post_rst_cyc", {28'd0, cyc_cnt}, 32'd0);
        chk("post_rst_instr", {28'd0, instr_cnt}, 32'd0);
        chk("post_rst_halted", {31'd0, halted}, 32'd0);

        // ADD: F D E W
        fde("add", SG_ADD, 1'b0, S_NONE);
        settle_chk("add_W", S_WB);
        step();
        settle_chk("add_back_F", S_FREQ);
        chk("add_cyc", {28'd0, cyc_cnt}, 32'd4);
        chk("add_instr", {28'd0, instr_cnt}, 32'd1);

        // LW with dmem_ack after three wait cycles: 8 cycles total
        do_reset();
        fde("lw", SG_LW, 1'b0, S_NONE);
        for (int i = 0; i < 3; i++) begin
            settle_chk("lw_M_wait", S_MRD);
            step();
        end
        dmem_ack = 1'b1;
        settle_chk("lw_M_ack", S_MRD);
        step(); dmem_ack = 1'b0;
        settle_chk("lw_W", S_WB);
        step();
        settle_chk("lw_back_F", S_FREQ);
        chk("lw_cyc", {28'd0, cyc_cnt}, 32'd8);
        chk("lw_instr", {28'd0, instr_cnt}, 32'd1);

        // SW: 4 cycles, dmem_we qualified
        do_reset();
        fde("sw", SG_SW, 1'b0, S_NONE);
        dmem_ack = 1'b1;
        settle_chk("sw_M", S_MWR);
        step(); dmem_ack = 1'b0;
        settle_chk("sw_back_F", S_FREQ);
        chk("sw_cyc", {28'd0, cyc_cnt}, 32'd4);

        // Branches, back to back: 3 cycles each; cyc reaches 15 after five
        do_reset();
        fde("beq_t", SG_BEQ, 1'b1, S_BR);
        chk("beq_cyc", {28'd0, cyc_cnt}, 32'd3);
        fde("beq_nt", SG_BEQ, 1'b0, S_NONE);
        fde("bne_nt", SG_BNE, 1'b1, S_NONE);
        fde("bne_t", SG_BNE, 1'b0, S_BR);
        fde("jmp", SG_J, 1'b0, S_BR);
        settle_chk("br_back_F", S_FREQ);
        chk("br_cyc", {28'd0, cyc_cnt}, 32'd15);
        chk("br_instr", {28'd0, instr_cnt}, 32'd5);

        // SYSCALL halt; go in the same EXEC cycle is ignored
        do_reset();
        sg = SG_SYS; imem_ack = 1'b1;
        step(); imem_ack = 1'b0;
        step();
        halt_req = 1'b1; go = 1'b1;
        settle_chk("sys_E", S_NONE);
        step();
        halt_req = 1'b0; go = 1'b0;
        settle_chk("halt_strobes", S_NONE);
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_instr", {28'd0, instr_cnt}, 32'd1);
        for (int i = 0; i < 10; i++) step();
        chk("halt_cyc_frozen", {28'd0, cyc_cnt}, 32'd3);
        chk("halt_still", {31'd0, halted}, 32'd1);
        go = 1'b1;
        step(); go = 1'b0;
        settle_chk("resume_F", S_FREQ);
        chk("resume_halted", {31'd0, halted}, 32'd0);
        chk("resume_cyc", {28'd0, cyc_cnt}, 32'd3);
        chk("resume_instr", {28'd0, instr_cnt}, 32'd1);

        // Reset while a data access is pending, then a late dmem_ack
        do_reset();
        fde("rmem", SG_LW, 1'b0, S_NONE);
        settle_chk("rmem_M", S_MRD);
        rst = 1'b1;
        settle_chk("rmem_rst_cycle", S_NONE);
        step();
        rst = 1'b0; dmem_ack = 1'b1;
        settle_chk("rmem_restart_F", S_FREQ);
        chk("rmem_cyc", {28'd0, cyc_cnt}, 32'd0);
        chk("rmem_instr", {28'd0, instr_cnt}, 32'd0);
        step(); dmem_ack = 1'b0;
        settle_chk("rmem_late_ack", S_FREQ);
        chk("rmem_cyc1", {28'd0, cyc_cnt}, 32'd1);

        // Saturation: 17 jumps retire past the 4-bit limit
        do_reset();
        for (int i = 0; i < 17; i++) fde("sat", SG_J, 1'b0, S_BR);
        chk("sat_instr", {28'd0, instr_cnt}, 32'd15);
        chk("sat_cyc", {28'd0, cyc_cnt}, 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
